tc_io_port: RTL and testbench

//  Peripheral end of the TinyComp I/O protocol: sources InData/InRdy, sinks output words.

---
 rtl/tc_io_port_pkg.sv | 15 +
 rtl/tc_sync_fifo.sv | 83 ++++++++
 rtl/tc_io_port.sv | 109 ++++++++++
 tb/tb_tc_io_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_io_port_pkg.sv
// Shared TinyComp I/O definitions: word width, FIFO sizing defaults and the
// I/O opcode values also decoded by the CPU.
package tc_io_port_pkg;

    localparam int unsigned TC_WORD_W = 32;
    localparam int unsigned TC_IN_AW  = 4;
    localparam int unsigned TC_OUT_AW = 4;

    // Opcodes that drive OutStrobe / InStrobe in the CPU decoder
    typedef enum logic [3:0] {
        OP_OUT = 4'd3,
        OP_IN  = 4'd5
    } tc_io_op_e;

endpackage : tc_io_port_pkg

// File: rtl/tc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset
//   push, din    write request (ignored while full) and write data
//   pop          read request (ignored while empty)
//   dout         registered head entry (0 after reset)
//   empty, full  status decoded from the occupancy count
//   count        occupancy, AW+1 bits
module tc_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    // Status from the pre-edge count: a pop in a full cycle never admits a push
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = push & ~w_full;
    assign w_pop   = pop & ~w_empty;

    // Next head: the word being written bypasses the array when it lands at the head slot
    assign w_rd_next   = r_rd_ptr + AW'(w_pop);
    assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? din : r_mem[w_rd_next];

    // Storage array, no reset needed
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push || w_pop) begin
                r_head <= w_head_next;
            end
        end
    end

    assign dout  = r_head;
    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_count;

endmodule : tc_sync_fifo

// File: rtl/tc_io_port.sv
// Peripheral end of the TinyComp I/O protocol, clocked on Ph0.
// Input side buffers words from a valid/ready source for CPU Input ops;
// output side captures CPU Output-op words and drains them to a valid/ready sink.
// Ports:
//   Clk, Reset                  Ph0 clock, synchronous active-high reset
//   InStrobe / InData / InRdy   CPU Input op, head word (0 when empty), non-empty
//   OutStrobe / OutData         CPU Output op and its data
//   SrcData/SrcValid/SrcReady   external source handshake
//   SnkData/SnkValid/SnkReady   external sink handshake
//   OutFull                     output FIFO full status
//   Overflow / Underflow        sticky error flags, cleared only by Reset
module tc_io_port
    import tc_io_port_pkg::*;
#(
    parameter int unsigned WIDTH  = TC_WORD_W,
    parameter int unsigned IN_AW  = TC_IN_AW,
    parameter int unsigned OUT_AW = TC_OUT_AW
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InStrobe,
    output logic [WIDTH-1:0] InData,
    output logic             InRdy,
    input  logic             OutStrobe,
    input  logic [WIDTH-1:0] OutData,
    input  logic [WIDTH-1:0] SrcData,
    input  logic             SrcValid,
    output logic             SrcReady,
    output logic [WIDTH-1:0] SnkData,
    output logic             SnkValid,
    input  logic             SnkReady,
    output logic             OutFull,
    output logic             Overflow,
    output logic             Underflow
);

    logic [WIDTH-1:0] w_in_head;
    logic             w_in_empty;
    logic             w_in_full;
    logic [IN_AW:0]   w_in_count;
    logic             w_in_push;
    logic             w_in_pop;

    logic [WIDTH-1:0] w_out_head;
    logic             w_out_empty;
    logic             w_out_full;
    logic [OUT_AW:0]  w_out_count;
    logic             w_out_push;
    logic             w_out_pop;

    logic             r_overflow;
    logic             r_underflow;

    // Strobe and handshake qualification against pre-edge status
    assign w_in_push  = SrcValid & ~w_in_full;
    assign w_in_pop   = InStrobe & ~w_in_empty;
    assign w_out_push = OutStrobe & ~w_out_full;
    assign w_out_pop  = SnkReady & ~w_out_empty;

    tc_sync_fifo #(.WIDTH(WIDTH), .AW(IN_AW)) u_in_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (w_in_push),
        .din   (SrcData),
        .pop   (w_in_pop),
        .dout  (w_in_head),
        .empty (w_in_empty),
        .full  (w_in_full),
        .count (w_in_count)
    );

    tc_sync_fifo #(.WIDTH(WIDTH), .AW(OUT_AW)) u_out_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (w_out_push),
        .din   (OutData),
        .pop   (w_out_pop),
        .dout  (w_out_head),
        .empty (w_out_empty),
        .full  (w_out_full),
        .count (w_out_count)
    );

    // Sticky error flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (OutStrobe && w_out_full) begin
                r_overflow <= 1'b1;
            end
            if (InStrobe && w_in_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Head words read as zero whenever their FIFO is empty
    assign InData    = w_in_empty  ? '0 : w_in_head;
    assign InRdy     = (w_in_count != '0);
    assign SrcReady  = ~w_in_full;
    assign SnkData   = w_out_empty ? '0 : w_out_head;
    assign SnkValid  = (w_out_count != '0);
    assign OutFull   = w_out_full;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule : tc_io_port

// File: tb/tb_tc_io_port.sv
// Scoreboard bench for tc_io_port: stimulus pushes expected words into queues,
// monitors pop and compare on every CPU pop and every sink handshake.
module tb_tc_io_port;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InStrobe;
    logic [31:0] InData;
    logic        InRdy;
    logic        OutStrobe;
    logic [31:0] OutData;
    logic [31:0] SrcData;
    logic        SrcValid;
    logic        SrcReady;
    logic [31:0] SnkData;
    logic        SnkValid;
    logic        SnkReady;
    logic        OutFull;
    logic        Overflow;
    logic        Underflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];

    always #5 Clk = ~Clk;

    tc_io_port dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InStrobe  (InStrobe),
        .InData    (InData),
        .InRdy     (InRdy),
        .OutStrobe (OutStrobe),
        .OutData   (OutData),
        .SrcData   (SrcData),
        .SrcValid  (SrcValid),
        .SrcReady  (SrcReady),
        .SnkData   (SnkData),
        .SnkValid  (SnkValid),
        .SnkReady  (SnkReady),
        .OutFull   (OutFull),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every CPU pop and every sink transfer against the scoreboard
    always @(negedge Clk) begin
        if (!Reset && InStrobe && InRdy) begin
            if (in_q.size() == 0) begin
                chk("in_pop_unexpected", InData, 32'hxxxx_xxxx);
            end else begin
                chk("in_pop_data", InData, in_q.pop_front());
            end
        end
        if (!Reset && SnkValid && SnkReady) begin
            if (out_q.size() == 0) begin
                chk("snk_unexpected", SnkData, 32'hxxxx_xxxx);
            end else begin
                chk("snk_data", SnkData, out_q.pop_front());
            end
        end
    end

    task automatic src_push(input logic [31:0] v);
        SrcData  = v;
        SrcValid = 1'b1;
        in_q.push_back(v);
        tick();
        SrcValid = 1'b0;
    endtask

    task automatic cpu_pop(input int n);
        InStrobe = 1'b1;
        repeat (n) tick();
        InStrobe = 1'b0;
    endtask

    task automatic cpu_out(input logic [31:0] v, input bit accepted);
        OutData   = v;
        OutStrobe = 1'b1;
        if (accepted) out_q.push_back(v);
        tick();
        OutStrobe = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_InData"},    InData, 32'h0);
        chk({tag, "_InRdy"},     32'(InRdy), 32'h0);
        chk({tag, "_SrcReady"},  32'(SrcReady), 32'h1);
        chk({tag, "_SnkValid"},  32'(SnkValid), 32'h0);
        chk({tag, "_SnkData"},   SnkData, 32'h0);
        chk({tag, "_OutFull"},   32'(OutFull), 32'h0);
        chk({tag, "_Overflow"},  32'(Overflow), 32'h0);
        chk({tag, "_Underflow"}, 32'(Underflow), 32'h0);
    endtask

    initial begin
        int guard;
        Reset = 1'b1; InStrobe = 1'b0; OutStrobe = 1'b0; OutData = '0;
        SrcData = '0; SrcValid = 1'b0; SnkReady = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk_reset_state("rst");

        // 1: single word through the input side
        src_push(32'hDEADBEEF);
        chk("t1_InRdy", 32'(InRdy), 32'h1);
        chk("t1_InData", InData, 32'hDEADBEEF);
        tick();
        cpu_pop(1);
        chk("t1_InRdy_after_pop", 32'(InRdy), 32'h0);
        chk("t1_InData_after_pop", InData, 32'h0);

        // 2: fill, blocked push during a pop in the full cycle, drain in order
        for (int k = 0; k < 16; k++) begin
            src_push(32'(k));
        end
        chk("t2_SrcReady_full", 32'(SrcReady), 32'h0);
        SrcData = 32'h0000_0BAD; SrcValid = 1'b1; InStrobe = 1'b1;
        tick();
        SrcValid = 1'b0;
        chk("t2_SrcReady_after_pop", 32'(SrcReady), 32'h1);
        chk("t2_InData_second", InData, 32'h1);
        cpu_pop(15);
        chk("t2_InRdy_drained", 32'(InRdy), 32'h0);

        // 3: underflow on empty, then normal operation
        cpu_pop(1);
        chk("t3_Underflow", 32'(Underflow), 32'h1);
        chk("t3_InRdy", 32'(InRdy), 32'h0);
        chk("t3_InData", InData, 32'h0);
        chk("t3_SrcReady", 32'(SrcReady), 32'h1);
        src_push(32'h0000_1234);
        chk("t3_InData_push", InData, 32'h0000_1234);
        cpu_pop(1);
        chk("t3_Underflow_sticky", 32'(Underflow), 32'h1);
        chk("t3_InRdy_end", 32'(InRdy), 32'h0);

        // 4: output FIFO overflow and ordered drain
        SnkReady = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cpu_out(32'h100 + 32'(k), 1'b1);
        end
        chk("t4_OutFull", 32'(OutFull), 32'h1);
        chk("t4_Overflow_pre", 32'(Overflow), 32'h0);
        cpu_out(32'h110, 1'b0);
        chk("t4_Overflow", 32'(Overflow), 32'h1);
        tick(); tick();
        chk("t4_SnkData_hold", SnkData, 32'h100);
        chk("t4_SnkValid_hold", 32'(SnkValid), 32'h1);
        SnkReady = 1'b1;
        guard = 0;
        while (out_q.size() != 0 && guard < 40) begin
            tick();
            guard++;
        end
        SnkReady = 1'b0;
        chk("t4_drain_in_budget", 32'(out_q.size()), 32'h0);
        tick();
        chk("t4_SnkValid_empty", 32'(SnkValid), 32'h0);
        chk("t4_OutFull_empty", 32'(OutFull), 32'h0);

        // 5: input FIFO at depth 3 with simultaneous push and pop
        src_push(32'h500); src_push(32'h501); src_push(32'h502);
        for (int i = 0; i < 10; i++) begin
            SrcData  = 32'h510 + 32'(i);
            SrcValid = 1'b1;
            InStrobe = 1'b1;
            in_q.push_back(32'h510 + 32'(i));
            tick();
        end
        SrcValid = 1'b0; InStrobe = 1'b0;
        chk("t5_InData_head", InData, 32'h517);
        cpu_pop(2);
        chk("t5_InRdy_one_left", 32'(InRdy), 32'h1);
        cpu_pop(1);
        chk("t5_InRdy_empty", 32'(InRdy), 32'h0);

        cpu_out(32'h700, 1'b1);
        OutData = 32'h701; OutStrobe = 1'b1; SnkReady = 1'b1;
        out_q.push_back(32'h701);
        tick();
        OutStrobe = 1'b0;
        chk("t5_SnkValid_stays", 32'(SnkValid), 32'h1);
        chk("t5_SnkData_next", SnkData, 32'h701);
        tick();
        SnkReady = 1'b0;
        chk("t5_SnkValid_drained", 32'(SnkValid), 32'h0);

        // 6: reset mid-stream discards everything and clears flags
        for (int k = 0; k < 8; k++) begin
            src_push(32'hA00 + 32'(k));
            cpu_out(32'hB00 + 32'(k), 1'b1);
        end
        chk("t6_InRdy_pre", 32'(InRdy), 32'h1);
        chk("t6_SnkValid_pre", 32'(SnkValid), 32'h1);
        SrcData = 32'hEEEE; SrcValid = 1'b1; Reset = 1'b1;
        tick();
        Reset = 1'b0; SrcValid = 1'b0;
        in_q.delete();
        out_q.delete();
        chk_reset_state("t6");
        src_push(32'hCAFE0001);
        chk("t6_InData_first", InData, 32'hCAFE0001);
        cpu_pop(1);

        tick();
        chk("end_in_q_empty", 32'(in_q.size()), 32'h0);
        chk("end_out_q_empty", 32'(out_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tc_io_port
